ccs_reg_access: RTL and testbench

Register-transaction engine between a CCS sensor driver and `i2c_master`. It accepts one 16-bit-addressed register read or write per handshake and expands it into the CCS byte sequence on `i2c_master`'s byte interface: address MSB, address LSB, then a data byte or a repeated-start read. It returns read data and error status to the driver. This removes per-driver byte counters and nack handling from sensor drivers.

---
 rtl/ccs_pkg.sv | 30 +++
 rtl/ccs_reg_access.sv | 194 +++++++++++++++++++
 tb/tb_ccs_reg_access.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ccs_pkg.sv
// Shared types for the CCS register-transaction engine.
// CCS_READBACK_EN adds the write-verify readback states to the state enum.
package ccs_pkg;

    localparam logic CCS_RD = 1'b1;
    localparam logic CCS_WR = 1'b0;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR_HI   = 4'd1,
        ADDR_LO   = 4'd2,
        DATA      = 4'd3,
        RD_START  = 4'd4,
        WAIT_DONE = 4'd5,
        RESP      = 4'd6
`ifdef CCS_READBACK_EN
        ,
        VFY_HI    = 4'd7,
        VFY_LO    = 4'd8,
        VFY_RD    = 4'd9
`endif
    } ccs_state_e;

    typedef struct packed {
        logic        read;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } ccs_req_t;

endpackage

// File: rtl/ccs_reg_access.sv
// Expands one 16-bit-addressed CCS register read/write into i2c_master byte steps.
// Define CCS_READBACK_EN to verify every successful write with a readback of the same register.
module ccs_reg_access
    import ccs_pkg::*;
#(
    parameter logic [7:0] ADDRESS = 8'h20
) (
    input  logic        clk_in,
    input  logic        reset_n,
    // Request/response: a request moves on req_valid && req_ready; rsp_valid is a
    // single-cycle pulse with no back-pressure, rsp_rdata holds until the next pulse.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  i2c_address,
    output logic        transfer_start,
    output logic        transfer_continues,
    output logic [7:0]  data_tx,
    input  logic        transfer_ready,
    input  logic        interrupt,
    input  logic        transaction_complete,
    input  logic        nack,
    input  logic        address_err,
    input  logic [7:0]  data_rx,
    output ccs_state_e  dbg_state
);

    ccs_state_e state_q, state_d;
    ccs_req_t   req_q, req_d;
    logic       i2c_rd_q, i2c_rd_d;
    logic       start_q, start_d;
    logic       cont_q, cont_d;
    logic [7:0] data_tx_q, data_tx_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;

    logic accept;
    logic advance;
    logic err_hit;

    assign accept  = req_valid && req_ready;
    assign advance = transfer_ready || interrupt;
    // Once the repeated start is out, a nack is the master's own end-of-read NACK.
    assign err_hit = interrupt && (address_err || (nack && !i2c_rd_q));

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            i2c_rd_q  <= 1'b0;
            start_q   <= 1'b0;
            cont_q    <= 1'b0;
            data_tx_q <= 8'h00;
            rdata_q   <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            i2c_rd_q  <= i2c_rd_d;
            start_q   <= start_d;
            cont_q    <= cont_d;
            data_tx_q <= data_tx_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = ADDR_HI;
            RESP: state_d = IDLE;
            default: begin
                if (err_hit) begin
                    state_d = RESP;
                end else begin
                    case (state_q)
                        ADDR_HI:  if (advance) state_d = ADDR_LO;
                        ADDR_LO:  if (advance) state_d = (req_q.read == CCS_RD) ? RD_START : DATA;
                        DATA:     if (advance) state_d = WAIT_DONE;
                        RD_START: if (advance) state_d = WAIT_DONE;
                        WAIT_DONE: begin
                            if (transaction_complete) begin
`ifdef CCS_READBACK_EN
                                state_d = i2c_rd_q ? RESP : VFY_HI;
`else
                                state_d = RESP;
`endif
                            end
                        end
`ifdef CCS_READBACK_EN
                        VFY_HI:   if (advance) state_d = VFY_LO;
                        VFY_LO:   if (advance) state_d = VFY_RD;
                        VFY_RD:   if (advance) state_d = WAIT_DONE;
`endif
                        default:  state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        req_d     = req_q;
        i2c_rd_d  = i2c_rd_q;
        start_d   = start_q;
        cont_d    = cont_q;
        data_tx_d = data_tx_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.read  = req_read;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    start_d     = 1'b1;
                    cont_d      = 1'b1;
                    i2c_rd_d    = 1'b0;
                    data_tx_d   = req_addr[15:8];
                    err_d       = 1'b0;
                end
            end
            RESP: ;
            default: begin
                if (err_hit) begin
                    start_d = 1'b0;
                    cont_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (state_q == WAIT_DONE) begin
                    if (transaction_complete) begin
                        if (i2c_rd_q) begin
                            rdata_d = data_rx;
`ifdef CCS_READBACK_EN
                            if (req_q.read == CCS_WR && data_rx != req_q.wdata) err_d = 1'b1;
                        end else begin
                            // Write landed; restart the same register as a read for verification.
                            start_d   = 1'b1;
                            cont_d    = 1'b1;
                            data_tx_d = req_q.addr[15:8];
`endif
                        end
                    end
                end else if (advance) begin
                    case (state_q)
                        ADDR_HI: begin
                            start_d   = 1'b0;
                            cont_d    = (req_q.read == CCS_WR);
                            data_tx_d = req_q.addr[7:0];
                        end
                        ADDR_LO: begin
                            cont_d = 1'b0;
                            if (req_q.read == CCS_RD) begin
                                start_d  = 1'b1;
                                i2c_rd_d = 1'b1;
                            end else begin
                                data_tx_d = req_q.wdata;
                            end
                        end
`ifdef CCS_READBACK_EN
                        VFY_HI: begin
                            start_d   = 1'b0;
                            cont_d    = 1'b1;
                            data_tx_d = req_q.addr[7:0];
                        end
                        VFY_LO: begin
                            start_d  = 1'b1;
                            cont_d   = 1'b0;
                            i2c_rd_d = 1'b1;
                        end
`endif
                        default: start_d = 1'b0;
                    endcase
                end
            end
        endcase
    end

    assign req_ready          = reset_n && (state_q == IDLE);
    assign rsp_valid          = (state_q == RESP);
    assign rsp_rdata          = rdata_q;
    assign rsp_err            = err_q;
    assign i2c_address        = ADDRESS + {7'b0, i2c_rd_q};
    assign transfer_start     = start_q;
    assign transfer_continues = cont_q;
    assign data_tx            = data_tx_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_ccs_reg_access.sv
// Directed bench for ccs_reg_access: a scripted i2c_master byte model plus a response scoreboard.
// Build with CCS_READBACK_EN to exercise the write-verify readback path.
module tb_ccs_reg_access;
    import ccs_pkg::*;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_read = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [7:0]  req_wdata = 8'h0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [7:0]  i2c_address;
    logic        transfer_start;
    logic        transfer_continues;
    logic [7:0]  data_tx;
    logic        transfer_ready = 1'b0;
    logic        interrupt = 1'b0;
    logic        transaction_complete = 1'b0;
    logic        nack = 1'b0;
    logic        address_err = 1'b0;
    logic [7:0]  data_rx = 8'h0;
    ccs_state_e  dbg_state;

    ccs_reg_access #(.ADDRESS(8'h20)) dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .i2c_address(i2c_address), .transfer_start(transfer_start),
        .transfer_continues(transfer_continues), .data_tx(data_tx),
        .transfer_ready(transfer_ready), .interrupt(interrupt),
        .transaction_complete(transaction_complete), .nack(nack),
        .address_err(address_err), .data_rx(data_rx), .dbg_state(dbg_state)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_mis = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;
    logic [8:0] exp_q[$];
    logic [7:0] model_rdata = 8'h00;

    always @(posedge clk_in) begin
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_ready"}, req_ready, 1'b1);
    endtask

    task automatic issue(input string tag, input logic rd, input logic [15:0] addr,
                         input logic [7:0] wd, input bit hold);
        req_read  = rd;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        wait_ready(tag);
        tick();
        if (!hold) req_valid = 1'b0;
        check_eq({tag, "_hi_state"}, dbg_state, ADDR_HI);
        check_eq({tag, "_hi_start"}, transfer_start, 1'b1);
        check_eq({tag, "_hi_cont"}, transfer_continues, 1'b1);
        check_eq({tag, "_hi_tx"}, data_tx, addr[15:8]);
        check_eq({tag, "_hi_ia"}, i2c_address, 8'h20);
        check_eq({tag, "_busy"}, req_ready, 1'b0);
    endtask

    // Model latency of two cycles per byte, then one transfer_ready (optionally with interrupt).
    task automatic advance_chk(input string tag, input bit both, input ccs_state_e st,
                               input logic s, input logic c, input logic [7:0] tx,
                               input logic [7:0] ia);
        repeat (2) tick();
        transfer_ready = 1'b1;
        interrupt      = both;
        tick();
        transfer_ready = 1'b0;
        interrupt      = 1'b0;
        check_eq({tag, "_state"}, dbg_state, st);
        check_eq({tag, "_start"}, transfer_start, s);
        check_eq({tag, "_cont"}, transfer_continues, c);
        check_eq({tag, "_tx"}, data_tx, tx);
        check_eq({tag, "_ia"}, i2c_address, ia);
    endtask

    task automatic pulse_tc(input logic [7:0] rx);
        tick();
        data_rx              = rx;
        transaction_complete = 1'b1;
        tick();
        transaction_complete = 1'b0;
        data_rx              = 8'h00;
    endtask

    task automatic check_resp(input string tag);
        logic [8:0] e;
        e = exp_q.pop_front();
        check_eq({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        check_eq({tag, "_rsp_err"}, rsp_err, e[8]);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, e[7:0]);
        tick();
        check_eq({tag, "_rsp_pulse"}, rsp_valid, 1'b0);
        check_eq({tag, "_ready_back"}, req_ready, 1'b1);
    endtask

    task automatic do_write(input string tag, input logic [15:0] addr, input logic [7:0] wd,
                            input logic [7:0] rb, input bit hold);
        issue(tag, CCS_WR, addr, wd, hold);
        advance_chk({tag, "_lo"}, 1'b0, ADDR_LO, 1'b0, 1'b1, addr[7:0], 8'h20);
        advance_chk({tag, "_data"}, 1'b0, DATA, 1'b0, 1'b0, wd, 8'h20);
        advance_chk({tag, "_wait"}, 1'b0, WAIT_DONE, 1'b0, 1'b0, wd, 8'h20);
`ifdef CCS_READBACK_EN
        pulse_tc(8'h00);
        check_eq({tag, "_vhi_state"}, dbg_state, VFY_HI);
        check_eq({tag, "_vhi_start"}, transfer_start, 1'b1);
        check_eq({tag, "_vhi_tx"}, data_tx, addr[15:8]);
        advance_chk({tag, "_vlo"}, 1'b0, VFY_LO, 1'b0, 1'b1, addr[7:0], 8'h20);
        advance_chk({tag, "_vrd"}, 1'b0, VFY_RD, 1'b1, 1'b0, addr[7:0], 8'h21);
        advance_chk({tag, "_vwait"}, 1'b0, WAIT_DONE, 1'b0, 1'b0, addr[7:0], 8'h21);
        model_rdata = rb;
        exp_q.push_back({rb != wd, rb});
        pulse_tc(rb);
`else
        exp_q.push_back({1'b0, model_rdata});
        pulse_tc(8'hEE ^ rb);
`endif
        check_resp(tag);
    endtask

    task automatic do_read(input string tag, input logic [15:0] addr, input logic [7:0] rx,
                           input bit nack_last, input bit both);
        issue(tag, CCS_RD, addr, 8'h00, 1'b0);
        advance_chk({tag, "_lo"}, both, ADDR_LO, 1'b0, 1'b0, addr[7:0], 8'h20);
        advance_chk({tag, "_rs"}, 1'b0, RD_START, 1'b1, 1'b0, addr[7:0], 8'h21);
        advance_chk({tag, "_wait"}, both, WAIT_DONE, 1'b0, 1'b0, addr[7:0], 8'h21);
        if (nack_last) begin
            interrupt = 1'b1;
            nack      = 1'b1;
            tick();
            interrupt = 1'b0;
            nack      = 1'b0;
            check_eq({tag, "_nack_state"}, dbg_state, WAIT_DONE);
            check_eq({tag, "_nack_no_rsp"}, rsp_valid, 1'b0);
        end
        model_rdata = rx;
        exp_q.push_back({1'b0, rx});
        pulse_tc(rx);
        check_resp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int rsp0;

        #12;
        check_eq("rst_ready", req_ready, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_start", transfer_start, 1'b0);
        check_eq("rst_cont", transfer_continues, 1'b0);
        check_eq("rst_tx", data_tx, 8'h00);
        check_eq("rst_state", dbg_state, IDLE);
        #10;
        reset_n = 1'b1;
        #1;
        check_eq("post_rst_ready", req_ready, 1'b1);
        tick();

        do_write("wr0100", 16'h0100, 8'h01, 8'h01, 1'b0);
        do_read("rd0000", 16'h0000, 8'h02, 1'b1, 1'b0);
        do_write("wr0301", 16'h0301, 8'h05, 8'h04, 1'b0);

        // Address-LSB nack on a write; transfer_ready in the same cycle must lose.
        issue("nk", CCS_WR, 16'h0042, 8'h07, 1'b0);
        advance_chk("nk_lo", 1'b0, ADDR_LO, 1'b0, 1'b1, 8'h42, 8'h20);
        repeat (2) tick();
        interrupt      = 1'b1;
        nack           = 1'b1;
        transfer_ready = 1'b1;
        tick();
        interrupt      = 1'b0;
        nack           = 1'b0;
        transfer_ready = 1'b0;
        check_eq("nk_start", transfer_start, 1'b0);
        check_eq("nk_cont", transfer_continues, 1'b0);
        check_eq("nk_ready_low", req_ready, 1'b0);
        exp_q.push_back({1'b1, model_rdata});
        check_resp("nk");

        // req_valid held high across three writes.
        acc0 = acc_cnt;
        rsp0 = rsp_cnt;
        do_write("b2b0", 16'h0010, 8'hA1, 8'hA1, 1'b1);
        do_write("b2b1", 16'h0011, 8'hB2, 8'hB2, 1'b1);
        do_write("b2b2", 16'h0012, 8'hC3, 8'hC3, 1'b0);
        repeat (3) tick();
        check_eq("b2b_accepts", acc_cnt - acc0, 3);
        check_eq("b2b_rsps", rsp_cnt - rsp0, 3);

        // Reset in the middle of a read, at ADDR_LO.
        rsp0 = rsp_cnt;
        issue("rst_mid", CCS_RD, 16'h1234, 8'h00, 1'b0);
        advance_chk("rst_mid_lo", 1'b0, ADDR_LO, 1'b0, 1'b0, 8'h34, 8'h20);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_state", dbg_state, IDLE);
        check_eq("rst_mid_tx", data_tx, 8'h00);
        check_eq("rst_mid_ready", req_ready, 1'b0);
        check_eq("rst_mid_cont", transfer_continues, 1'b0);
        #3;
        reset_n = 1'b1;
        tick();
        check_eq("rst_mid_no_rsp", rsp_cnt - rsp0, 0);
        check_eq("rst_mid_rdata", rsp_rdata, 8'h00);
        model_rdata = 8'h00;
        do_read("rd_after_rst", 16'h00FF, 8'h5A, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
